vga_stream_sequencer: RTL and testbench
=======================================

// Module: vga_stream_sequencer
// PURPOSE
//  Pixel-domain sequencer between the framebuffer async FIFO read port and the VGA RGB output.
//  - Flushes and primes the FIFO, then starts reading on a frame boundary.
//  - Pops one 32-bit word per active pixel.
//  - On underflow or frame misalignment, resynchronises: flush, restart the SDRAM stream, re-prime.
// PARAMETERS
//  HDISP          800          active pixels per line
//  VDISP          480          active lines per frame
//  FLUSH_CYCLES   4            cycles fifo_flush/stream_restart held in IDLE (>=1)
//  UNDERFLOW_RGB  24'hFF00FF   colour shown after underflow (only with VGA_UNDERFLOW_COLOR_EN)
//  CNT_W          16           width of underflow_cnt
// PORTS
//  pixel_clk          in   1      pixel clock
//  pixel_rst          in   1      reset
//  pix_active         in   1      current timing-generator pixel is in the display area
//  frame_start        in   1      1-cycle pulse coincident with active pixel x=0,y=0
//  fifo_rdata         in   32     show-ahead FIFO head word, valid while !fifo_rempty; RGB in [23:0]
//  fifo_rempty        in   1      FIFO empty (read domain)
//  fifo_walmost_full  in   1      FIFO almost-full from write clock domain; asynchronous here
//  fifo_read          out  1      pop FIFO head this cycle (combinational)
//  fifo_flush         out  1      FIFO flush request (combinational from state)
//  stream_restart     out  1      request SDRAM reader restart at address 0 (level)
//  rgb                out  24     registered pixel colour
//  streaming          out  1      1 while in STREAM
//  underflow_cnt      out  CNT_W  saturating resync-event count
// BEHAVIOUR
//  Interface: reset pixel_rst, asynchronous, active-high; clock pixel_clk.
//  Reset values: state=IDLE, so fifo_flush=1, stream_restart=1.
//    rgb=0, streaming=0, underflow_cnt=0, flush counter=0, pixel counter=0, synchroniser=0.
//  fifo_walmost_full goes through a 2-flop synchroniser (afull_s); latency 2 cycles.
//  States:
//  - IDLE: fifo_flush=stream_restart=1.
//      Stays FLUSH_CYCLES cycles, then goes to FILL.
//  - FILL: waits for afull_s=1, then goes to ARMED.
//      A frame_start seen here is ignored.
//  - ARMED: on frame_start & pix_active & !fifo_rempty, goes to STREAM.
//      That word is popped in the same cycle; pixel counter <= 1.
//      If fifo_rempty at frame_start, stays ARMED.
//  - STREAM: fifo_read = pix_active & !fifo_rempty; pixel counter +1 per pop.
//      Counter wraps HDISP*VDISP-1 -> 0.
//      pix_active & fifo_rempty -> underflow: no pop, underflow_cnt+1, go to DRAIN.
//      frame_start with pixel counter != 0 -> misalignment: underflow_cnt+1, go to IDLE.
//        Misalignment has priority over underflow in the same cycle; counted once.
//  - DRAIN: no pops; waits for frame_start, then goes to IDLE.
//  fifo_read is never 1 outside ARMED/STREAM, and never while fifo_rempty.
//  rgb <= fifo_read ? fifo_rdata[23:0] : (pix_active ? fill : 24'h0).
//    Latency is 1 cycle from pix_active to rgb.
//    fill = 0 except as given under CONFIGURATION.
//  underflow_cnt saturates at all-ones; it is never cleared except by reset.
//  Reset mid-frame: immediate return to reset values; the next run re-primes from IDLE.
// CONFIGURATION
//  Macro VGA_UNDERFLOW_COLOR_EN.
//  - Defined: fill=UNDERFLOW_RGB for active pixels while in DRAIN; 0 in all other states.
//  - Undefined: fill is always 24'h0; UNDERFLOW_RGB is unused.
// STRUCTURE
//  Package vga_stream_pkg:
//  - typedef enum logic [2:0] {IDLE,FILL,ARMED,STREAM,DRAIN} seq_state_t
//  - FIFO_DW=32, RGB_W=24
//  Sub-module sync_2ff: generic 1-bit 2-flop synchroniser with async reset.
//  Instantiated once, for fifo_walmost_full.
// TESTING
//  1. Release reset; afull=1 from cycle 10; frame_start at cycle 40 with rdata=32'h00123456.
//     -> flush/restart high cycles 0-3; fifo_read=1 at cycle 40; rgb=24'h123456 at cycle 41; streaming=1.
//  2. Full 800x480 frame with FIFO never empty.
//     -> exactly 384000 pops; counter wraps to 0; next frame_start keeps STREAM; underflow_cnt=0.
//  3. fifo_rempty=1 at active pixel 1000.
//     -> fifo_read=0; underflow_cnt=1; DRAIN; rgb=FF00FF (macro) or 0; on next frame_start, IDLE flush for 4 cycles.
//  4. Spurious frame_start at pixel 500 of STREAM.
//     -> underflow_cnt+1; IDLE next cycle; fifo_flush=1.
//  5. CNT_W=4 with 20 forced underflows -> underflow_cnt holds 15.
//  6. pixel_rst pulse mid-STREAM -> rgb=0, streaming=0, fifo_flush=1 the same cycle; resumes only after refill and frame_start.

Source files
------------

// File: rtl/vga_stream_sequencer_pkg.sv
// Shared types and widths for the VGA stream sequencer.
package vga_stream_pkg;
  localparam int FIFO_DW = 32;
  localparam int RGB_W   = 24;

  typedef enum logic [2:0] {IDLE, FILL, ARMED, STREAM, DRAIN} seq_state_t;
endpackage

// File: rtl/vga_stream_sequencer_if.sv
// Framebuffer FIFO read-port bundle; master = sequencer, slave = FIFO.
interface vga_stream_sequencer_if;
  import vga_stream_pkg::*;

  logic [FIFO_DW-1:0] fifo_rdata;
  logic               fifo_rempty;
  logic               fifo_walmost_full;
  logic               fifo_read;
  logic               fifo_flush;

  modport master (
    input  fifo_rdata, fifo_rempty, fifo_walmost_full,
    output fifo_read, fifo_flush
  );

  modport slave (
    output fifo_rdata, fifo_rempty, fifo_walmost_full,
    input  fifo_read, fifo_flush
  );
endinterface

// File: rtl/vga_stream_sequencer_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with asynchronous active-high reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/vga_stream_sequencer.sv
// Pixel-domain sequencer: primes the framebuffer FIFO, pops one word per active pixel, resyncs on faults.
// Build option VGA_UNDERFLOW_COLOR_EN paints UNDERFLOW_RGB on active pixels while draining.
module vga_stream_sequencer
  import vga_stream_pkg::*;
#(
  parameter int               HDISP         = 800,
  parameter int               VDISP         = 480,
  parameter int               FLUSH_CYCLES  = 4,
  parameter logic [RGB_W-1:0] UNDERFLOW_RGB = 24'hFF00FF,
  parameter int               CNT_W         = 16
) (
  input  logic                   pixel_clk,
  input  logic                   pixel_rst,
  input  logic                   pix_active,
  input  logic                   frame_start,
  vga_stream_sequencer_if.master fifo,
  output logic                   stream_restart,
  output logic [RGB_W-1:0]       rgb,
  output logic                   streaming,
  output logic [CNT_W-1:0]       underflow_cnt
);
  localparam int NPIX  = HDISP * VDISP;
  localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(NPIX - 1);
  localparam logic [FC_W-1:0]  FLUSH_LAST = FC_W'(FLUSH_CYCLES - 1);
`ifdef VGA_UNDERFLOW_COLOR_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  seq_state_t       r_state, w_next;
  logic [FC_W-1:0]  r_flush_cnt, w_flush_cnt_nx;
  logic [PIX_W-1:0] r_pix_cnt, w_pix_cnt_nx;
  logic [RGB_W-1:0] r_rgb, w_fill;
  logic [CNT_W-1:0] r_uf_cnt;
  logic             w_read, w_resync, w_afull_s;
  logic             w_unused_rdata;

  sync_2ff u_afull_sync (
    .i_clk (pixel_clk),
    .i_rst (pixel_rst),
    .i_d   (fifo.fifo_walmost_full),
    .o_q   (w_afull_s)
  );

  always_comb begin
    w_next         = r_state;
    w_flush_cnt_nx = r_flush_cnt;
    w_pix_cnt_nx   = r_pix_cnt;
    w_read         = 1'b0;
    w_resync       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_flush_cnt == FLUSH_LAST) begin
          w_flush_cnt_nx = '0;
          w_next         = FILL;
        end else begin
          w_flush_cnt_nx = r_flush_cnt + 1'b1;
        end
      end
      FILL:  if (w_afull_s) w_next = ARMED;
      ARMED: begin
        if (frame_start && pix_active && !fifo.fifo_rempty) begin
          w_read       = 1'b1;
          w_pix_cnt_nx = PIX_W'(1);
          w_next       = STREAM;
        end
      end
      STREAM: begin
        w_read = pix_active && !fifo.fifo_rempty;
        if (w_read) w_pix_cnt_nx = (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
        // Misalignment wins over a coincident underflow and is counted once.
        if (frame_start && (r_pix_cnt != '0)) begin
          w_resync = 1'b1;
          w_next   = IDLE;
        end else if (pix_active && fifo.fifo_rempty) begin
          w_resync = 1'b1;
          w_next   = DRAIN;
        end
      end
      DRAIN:   if (frame_start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_fill = (FILL_EN && (r_state == DRAIN)) ? UNDERFLOW_RGB : '0;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      r_state     <= IDLE;
      r_flush_cnt <= '0;
      r_pix_cnt   <= '0;
      r_rgb       <= '0;
      r_uf_cnt    <= '0;
    end else begin
      r_state     <= w_next;
      r_flush_cnt <= w_flush_cnt_nx;
      r_pix_cnt   <= w_pix_cnt_nx;
      r_rgb       <= w_read ? fifo.fifo_rdata[RGB_W-1:0] : (pix_active ? w_fill : '0);
      if (w_resync && (r_uf_cnt != '1)) r_uf_cnt <= r_uf_cnt + 1'b1;
    end
  end

  assign fifo.fifo_read  = w_read;
  assign fifo.fifo_flush = (r_state == IDLE);
  assign stream_restart  = (r_state == IDLE);
  assign streaming       = (r_state == STREAM);
  assign rgb             = r_rgb;
  assign underflow_cnt   = r_uf_cnt;
  assign w_unused_rdata  = ^fifo.fifo_rdata[FIFO_DW-1:RGB_W];
endmodule

// File: tb/tb_vga_stream_sequencer.sv
// Self-checking bench for vga_stream_sequencer on a reduced raster with a small saturating counter.
module tb_vga_stream_sequencer;
  localparam int HDISP = 10, VDISP = 4, FLUSH = 4, CNT_W = 4;
  localparam int NPIX  = HDISP * VDISP;
  localparam int H_TOT = HDISP + 2, V_TOT = VDISP + 1, F_TOT = H_TOT * V_TOT;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [23:0] URGB = 24'hFF00FF;
`ifdef VGA_UNDERFLOW_COLOR_EN
  localparam bit COLOR_EN = 1'b1;
`else
  localparam bit COLOR_EN = 1'b0;
`endif

  logic             pixel_clk = 1'b0;
  logic             pixel_rst = 1'b1;
  logic             pix_active = 1'b0, frame_start = 1'b0;
  logic             stream_restart, streaming;
  logic [23:0]      rgb;
  logic [CNT_W-1:0] underflow_cnt;

  vga_stream_sequencer_if fif ();

  vga_stream_sequencer #(
    .HDISP(HDISP), .VDISP(VDISP), .FLUSH_CYCLES(FLUSH),
    .UNDERFLOW_RGB(URGB), .CNT_W(CNT_W)
  ) dut (
    .pixel_clk      (pixel_clk),
    .pixel_rst      (pixel_rst),
    .pix_active     (pix_active),
    .frame_start    (frame_start),
    .fifo           (fif),
    .stream_restart (stream_restart),
    .rgb            (rgb),
    .streaming      (streaming),
    .underflow_cnt  (underflow_cnt)
  );

  always #5 pixel_clk = ~pixel_clk;

  // Reference model: what the sequencer is doing, in spec terms.
  typedef enum {PRIME_FLUSH, PRIME_WAIT, WAIT_FRAME, RUN, HOLD} phase_t;
  phase_t      m_ph;
  int          m_flush_left, m_pos, m_cnt;
  logic [1:0]  m_af;
  logic [23:0] m_rgb;

  int n_vec = 0, n_err = 0, rt = 0, n_pops = 0;
  logic o_read, o_flush, o_stream, o_fs;
  logic [23:0] o_rgb;
  logic [CNT_W-1:0] o_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = PRIME_FLUSH; m_flush_left = FLUSH; m_af = 2'b00;
    m_pos = 0; m_rgb = 24'h0; m_cnt = 0;
  endtask

  task automatic bump();
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic step(input logic pa, input logic fs, input logic em, input logic af,
                      input logic [31:0] rd);
    logic e_read, e_flush;
    logic [23:0] fill;
    pix_active = pa; frame_start = fs; fif.fifo_rempty = em;
    fif.fifo_walmost_full = af; fif.fifo_rdata = rd;
    #1;
    e_flush = (m_ph == PRIME_FLUSH);
    e_read  = (m_ph == WAIT_FRAME) ? (fs && pa && !em) : (m_ph == RUN) ? (pa && !em) : 1'b0;
    chk("fifo_read", fif.fifo_read, e_read);
    chk("fifo_flush", fif.fifo_flush, e_flush);
    chk("stream_restart", stream_restart, e_flush);
    chk("streaming", streaming, m_ph == RUN);
    chk("rgb", rgb, m_rgb);
    chk("underflow_cnt", underflow_cnt, m_cnt);
    o_read = fif.fifo_read; o_flush = fif.fifo_flush; o_stream = streaming;
    o_rgb = rgb; o_cnt = underflow_cnt; o_fs = fs;
    if (fif.fifo_read === 1'b1) n_pops++;
    fill  = (COLOR_EN && m_ph == HOLD) ? URGB : 24'h0;
    m_rgb = e_read ? rd[23:0] : (pa ? fill : 24'h0);
    case (m_ph)
      PRIME_FLUSH: begin m_flush_left--; if (m_flush_left == 0) m_ph = PRIME_WAIT; end
      PRIME_WAIT:  if (m_af[1]) m_ph = WAIT_FRAME;
      WAIT_FRAME:  if (e_read) begin m_ph = RUN; m_pos = 1; end
      RUN: begin
        if (fs && m_pos != 0) begin bump(); m_ph = PRIME_FLUSH; m_flush_left = FLUSH; end
        else if (pa && em) begin bump(); m_ph = HOLD; end
        if (e_read) m_pos = (m_pos + 1) % NPIX;
      end
      HOLD: if (fs) begin m_ph = PRIME_FLUSH; m_flush_left = FLUSH; end
      default: ;
    endcase
    m_af = {m_af[0], af};
    @(negedge pixel_clk);
  endtask

  function automatic int cur_aidx();
    int p, hx, vy;
    p = rt % F_TOT; hx = p % H_TOT; vy = p / H_TOT;
    return ((hx < HDISP) && (vy < VDISP)) ? vy * HDISP + hx : -1;
  endfunction

  task automatic rstep(input logic em, input logic af, input logic extra_fs);
    logic pa, fs;
    pa = (cur_aidx() >= 0);
    fs = ((rt % F_TOT) == 0) || extra_fs;
    rt++;
    step(pa, fs, em, af, $urandom);
  endtask

  task automatic wait_run(input string tag);
    for (int b = 0; b < 4 * F_TOT && m_ph != RUN; b++) rstep(1'b0, 1'b1, 1'b0);
    chk(tag, streaming, 1'b1);
  endtask

  initial begin
    int k, p, nf;
    logic em, hit, seen, prev_fs;
    fif.fifo_rdata = '0; fif.fifo_rempty = 1'b0; fif.fifo_walmost_full = 1'b0;
    #1;
    chk("rst_flush", fif.fifo_flush, 1'b1);
    chk("rst_restart", stream_restart, 1'b1);
    chk("rst_rgb", rgb, 24'h0);
    chk("rst_streaming", streaming, 1'b0);
    chk("rst_cnt", underflow_cnt, 0);
    chk("rst_read", fif.fifo_read, 1'b0);
    model_reset();
    @(negedge pixel_clk); @(negedge pixel_clk);
    pixel_rst = 1'b0;

    // T1: priming, then first frame start with a known word
    for (int c = 0; c < 40; c++) begin
      step(1'b0, 1'b0, 1'b0, c >= 10, $urandom);
      if (c < 4) chk("t1_flush_hi", o_flush, 1'b1);
      else if (c == 4) chk("t1_flush_lo", o_flush, 1'b0);
    end
    n_pops = 0;
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h00123456);
    rt = 1;
    chk("t1_read_c40", o_read, 1'b1);
    rstep(1'b0, 1'b1, 1'b0);
    chk("t1_rgb_c41", o_rgb, 24'h123456);
    chk("t1_streaming_c41", o_stream, 1'b1);

    // T2: a whole frame with the FIFO never empty
    while (rt < F_TOT) rstep(1'b0, 1'b1, 1'b0);
    chk("t2_pops_frame", n_pops, NPIX);
    repeat (2) rstep(1'b0, 1'b1, 1'b0);
    chk("t2_stream_after_fs", o_stream, 1'b1);
    chk("t2_cnt", underflow_cnt, 0);

    // T3: underflow at a random active pixel
    k = $urandom_range(1, NPIX - 3);
    hit = 1'b0;
    for (int b = 0; b < 3 * F_TOT && !hit; b++) begin
      em = (m_ph == RUN) && (cur_aidx() == k);
      rstep(em, 1'b1, 1'b0);
      if (em) begin hit = 1'b1; chk("t3_no_read", o_read, 1'b0); end
    end
    chk("t3_injected", hit, 1'b1);
    rstep(1'b0, 1'b1, 1'b0);
    chk("t3_cnt", o_cnt, 1);
    chk("t3_drain", o_stream, 1'b0);
    for (int b = 0; b < F_TOT && cur_aidx() < 0; b++) rstep(1'b0, 1'b1, 1'b0);
    rstep($urandom_range(0, 1), 1'b1, 1'b0);
    rstep(1'b0, 1'b1, 1'b0);
    chk("t3_fill_rgb", o_rgb, COLOR_EN ? URGB : 24'h0);
    for (int b = 0; b < 2 * F_TOT && (rt % F_TOT) != 0; b++) rstep($urandom_range(0, 1), 1'b1, 1'b0);
    rstep(1'b0, 1'b1, 1'b0);
    nf = 0;
    for (int i = 0; i < FLUSH + 2; i++) begin rstep(1'b0, 1'b1, 1'b0); if (o_flush) nf++; end
    chk("t3_flush_cycles", nf, FLUSH);
    for (int b = 0; b < 2 * F_TOT && (rt % F_TOT) != 0; b++) rstep(1'b0, 1'b1, 1'b0);
    rstep(1'b1, 1'b1, 1'b0);
    chk("t3_armed_empty_no_read", o_read, 1'b0);
    rstep(1'b0, 1'b1, 1'b0);
    chk("t3_armed_holds", o_stream, 1'b0);
    wait_run("t3_resume");

    // T4: spurious frame_start mid-frame
    p = $urandom_range(1, NPIX - 1);
    hit = 1'b0;
    for (int b = 0; b < 2 * F_TOT && !hit; b++) begin
      em = (m_ph == RUN) && (cur_aidx() == p);
      rstep(1'b0, 1'b1, em);
      hit = em;
    end
    rstep(1'b0, 1'b1, 1'b0);
    chk("t4_cnt", o_cnt, 2);
    chk("t4_flush", o_flush, 1'b1);

    // T5: twenty more forced underflows saturate the counter
    for (int i = 0; i < 20; i++) begin
      wait_run("t5_run");
      hit = 1'b0;
      for (int b = 0; b < 2 * F_TOT && !hit; b++) begin
        em = (m_ph == RUN) && (cur_aidx() >= 0) && ($urandom_range(0, 2) == 0);
        rstep(em, 1'b1, 1'b0);
        hit = em;
      end
    end
    chk("t5_sat", underflow_cnt, CNT_MAX);

    // T6: reset pulse while streaming
    wait_run("t6_run");
    repeat (5) rstep(1'b0, 1'b1, 1'b0);
    pixel_rst = 1'b1;
    #1;
    chk("t6_rgb", rgb, 24'h0);
    chk("t6_streaming", streaming, 1'b0);
    chk("t6_flush", fif.fifo_flush, 1'b1);
    chk("t6_cnt", underflow_cnt, 0);
    model_reset();
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    seen = 1'b0; prev_fs = 1'b0;
    for (int b = 0; b < 5 * F_TOT && !seen; b++) begin
      rstep(1'b0, b >= 20, 1'b0);
      if (o_stream) begin seen = 1'b1; chk("t6_resume_after_fs", prev_fs, 1'b1); end
      prev_fs = o_fs;
    end
    chk("t6_resumed", seen, 1'b1);
    repeat (F_TOT) rstep(1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
